// File: rtl/frame_buf_ctrl_pkg.sv
// Shared types and constants for the frame buffer sequencer: buffer states,
// port FSM encodings and active-low enable levels.
package frame_buf_pkg;

    typedef enum logic [1:0] {
        B_FREE     = 2'd0,
        B_FILLING  = 2'd1,
        B_FULL     = 2'd2,
        B_DRAINING = 2'd3
    } buf_state_e;

    // One encoding serves both sides; the per-side names alias it.
    typedef enum logic {
        P_WAIT = 1'b0,
        P_BUSY = 1'b1
    } port_fsm_e;

    localparam port_fsm_e W_WAIT = P_WAIT;
    localparam port_fsm_e W_FILL = P_BUSY;
    localparam port_fsm_e R_WAIT = P_WAIT;
    localparam port_fsm_e R_READ = P_BUSY;

    localparam logic ASSERT   = 1'b0;
    localparam logic DEASSERT = 1'b1;

endpackage

// File: rtl/frame_buf_ctrl_if.sv
// Handshake and memory-control bundle between the pixel ports, the sequencer
// and data_mem. slave = sequencer side, master = source/sink side.
interface frame_buf_ctrl_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_BUFS   = 2,
    parameter int BUF_W      = $clog2(NUM_BUFS)
);
    logic                        wr_en_in;
    logic                        wr_abort;
    logic                        rd_en_in;
    logic                        wr_rdy;
    logic                        rd_rdy;
    logic                        mem_wr_en;
    logic                        mem_rd_en;
    logic [BUF_W+ADDR_WIDTH-1:0] mem_wr_addr;
    logic [BUF_W+ADDR_WIDTH-1:0] mem_rd_addr;
    logic                        rd_data_vld;
    logic                        frame_done;
    logic                        frame_read;
    logic [BUF_W:0]              full_cnt;

    modport master (
        output wr_en_in, wr_abort, rd_en_in,
        input  wr_rdy, rd_rdy, mem_wr_en, mem_rd_en, mem_wr_addr, mem_rd_addr,
               rd_data_vld, frame_done, frame_read, full_cnt
    );

    modport slave (
        input  wr_en_in, wr_abort, rd_en_in,
        output wr_rdy, rd_rdy, mem_wr_en, mem_rd_en, mem_wr_addr, mem_rd_addr,
               rd_data_vld, frame_done, frame_read, full_cnt
    );
endinterface

// File: rtl/frame_buf_ctrl_port_seq.sv
// One side (writer or reader) of the frame sequencer: port FSM, word counter,
// buffer pointer, last-word detect and the state request for the pointed buffer.
module frame_port_seq
    import frame_buf_pkg::*;
#(
    parameter int         ADDR_WIDTH = 3,
    parameter int         NUM_BUFS   = 2,
    parameter int         BUF_W      = $clog2(NUM_BUFS),
    parameter buf_state_e CLAIM      = B_FREE,
    parameter buf_state_e HOLD       = B_FILLING,
    parameter buf_state_e DONE       = B_FULL,
    parameter bit         ABORTABLE  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_n,
    input  logic                  abort_n,
    input  buf_state_e            cur_state,
    output logic                  rdy,
    output logic                  accept,
    output logic                  last,
    output logic                  upd,
    output buf_state_e            nxt_state,
    output logic                  pulse,
    output logic [BUF_W-1:0]      ptr,
    output logic [ADDR_WIDTH-1:0] word
);

    port_fsm_e fsm;
    logic      abort_fire;

    assign rdy = (cur_state == CLAIM) || (cur_state == HOLD);

    // Gating with reset keeps the memory enables quiet while reset is held.
    assign abort_fire = ABORTABLE && reset && (abort_n == ASSERT) && (fsm == P_BUSY);
    assign accept     = reset && (en_n == ASSERT) && rdy && !abort_fire;
    assign last       = accept && (&word);

    assign upd       = accept || abort_fire;
    assign nxt_state = abort_fire ? CLAIM : (last ? DONE : HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm   <= P_WAIT;
            ptr   <= '0;
            word  <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= last;
            if (abort_fire) begin
                fsm  <= P_WAIT;
                word <= '0;
            end else if (accept) begin
                word <= word + 1'b1;
                if (last) begin
                    ptr <= ptr + 1'b1;
                    fsm <= P_WAIT;
                end else begin
                    fsm <= P_BUSY;
                end
            end
        end
    end

endmodule

// File: rtl/frame_buf_ctrl.sv
// Multi-buffer frame sequencer: hands the writer the next free buffer and the
// reader the oldest full one, and drives data_mem enables and addresses.
module frame_buf_ctrl
    import frame_buf_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_BUFS   = 2,
    parameter int BUF_W      = $clog2(NUM_BUFS)
) (
    input  logic           clk,
    input  logic           reset,
    frame_buf_ctrl_if.slave bus
);

    localparam int RD_LAT = 1;

    buf_state_e            bstate [NUM_BUFS];

    logic                  wr_rdy, wr_acc, wr_last, wr_upd, wr_pulse;
    logic                  rd_rdy, rd_acc, rd_last, rd_upd, rd_pulse;
    buf_state_e            wr_nxt, rd_nxt;
    logic [BUF_W-1:0]      wr_ptr, rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_word, rd_word;
    logic [BUF_W:0]        full_cnt;
    logic [RD_LAT:1]       vld_pipe;

    frame_port_seq #(
        .ADDR_WIDTH(ADDR_WIDTH), .NUM_BUFS(NUM_BUFS), .BUF_W(BUF_W),
        .CLAIM(B_FREE), .HOLD(B_FILLING), .DONE(B_FULL), .ABORTABLE(1'b1)
    ) u_wr (
        .clk(clk), .reset(reset), .en_n(bus.wr_en_in), .abort_n(bus.wr_abort),
        .cur_state(bstate[wr_ptr]), .rdy(wr_rdy), .accept(wr_acc), .last(wr_last),
        .upd(wr_upd), .nxt_state(wr_nxt), .pulse(wr_pulse), .ptr(wr_ptr), .word(wr_word)
    );

    frame_port_seq #(
        .ADDR_WIDTH(ADDR_WIDTH), .NUM_BUFS(NUM_BUFS), .BUF_W(BUF_W),
        .CLAIM(B_FULL), .HOLD(B_DRAINING), .DONE(B_FREE), .ABORTABLE(1'b0)
    ) u_rd (
        .clk(clk), .reset(reset), .en_n(bus.rd_en_in), .abort_n(DEASSERT),
        .cur_state(bstate[rd_ptr]), .rdy(rd_rdy), .accept(rd_acc), .last(rd_last),
        .upd(rd_upd), .nxt_state(rd_nxt), .pulse(rd_pulse), .ptr(rd_ptr), .word(rd_word)
    );

    // The two sides never point at the same buffer while both update it:
    // FILLING blocks the reader and DRAINING blocks the writer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BUFS; i++) bstate[i] <= B_FREE;
        end else begin
            if (wr_upd) bstate[wr_ptr] <= wr_nxt;
            if (rd_upd) bstate[rd_ptr] <= rd_nxt;
        end
    end

    // Counted on the same edge as the buffer states, so it always equals the
    // number of FULL/DRAINING buffers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_cnt <= '0;
        end else begin
            case ({wr_last, rd_last})
                2'b10:   full_cnt <= full_cnt + 1'b1;
                2'b01:   full_cnt <= full_cnt - 1'b1;
                default: full_cnt <= full_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            for (int s = 2; s <= RD_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    assign bus.wr_rdy      = wr_rdy;
    assign bus.rd_rdy      = rd_rdy;
    assign bus.mem_wr_en   = wr_acc ? ASSERT : DEASSERT;
    assign bus.mem_rd_en   = rd_acc ? ASSERT : DEASSERT;
    assign bus.mem_wr_addr = {wr_ptr, wr_word};
    assign bus.mem_rd_addr = {rd_ptr, rd_word};
    assign bus.rd_data_vld = vld_pipe[RD_LAT];
    assign bus.frame_done  = wr_pulse;
    assign bus.frame_read  = rd_pulse;
    assign bus.full_cnt    = full_cnt;

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Scoreboarded bench for frame_buf_ctrl: a per-cycle behavioural model predicts
// enables, addresses, rdy flags, pulses and full_cnt for directed and random traffic.
module tb_frame_buf_ctrl;
    localparam int AW    = 3;
    localparam int NB    = 2;
    localparam int FRAME = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b0;

    frame_buf_ctrl_if #(.ADDR_WIDTH(AW), .NUM_BUFS(NB)) bus ();

    frame_buf_ctrl #(.ADDR_WIDTH(AW), .NUM_BUFS(NB)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fd;
        int fr;
        int vld;
        int full;
    } post_t;

    post_t exp_q[$];
    int    n_chk = 0;
    int    n_err = 0;

    // model: 0 FREE, 1 FILLING, 2 FULL, 3 DRAINING
    int mb [NB];
    int m_wb, m_rb, m_ww, m_rw;
    bit m_wfill;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) mb[i] = 0;
        m_wb = 0; m_rb = 0; m_ww = 0; m_rw = 0; m_wfill = 1'b0;
        exp_q.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".mem_wr_en"},   int'(bus.mem_wr_en),   1);
        chk({tag, ".mem_rd_en"},   int'(bus.mem_rd_en),   1);
        chk({tag, ".wr_rdy"},      int'(bus.wr_rdy),      1);
        chk({tag, ".rd_rdy"},      int'(bus.rd_rdy),      0);
        chk({tag, ".mem_wr_addr"}, int'(bus.mem_wr_addr), 0);
        chk({tag, ".mem_rd_addr"}, int'(bus.mem_rd_addr), 0);
        chk({tag, ".rd_data_vld"}, int'(bus.rd_data_vld), 0);
        chk({tag, ".frame_done"},  int'(bus.frame_done),  0);
        chk({tag, ".frame_read"},  int'(bus.frame_read),  0);
        chk({tag, ".full_cnt"},    int'(bus.full_cnt),    0);
    endtask

    task automatic idle_inputs();
        bus.wr_en_in = 1'b1; bus.wr_abort = 1'b1; bus.rd_en_in = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // One cycle: drive at negedge, check combinational outputs, push the
    // post-edge expectation, then pop and compare after the edge.
    task automatic step(input bit w, input bit a, input bit r);
        post_t e;
        bit wrdy, rrdy, ab, wacc, racc;
        int cnt;
        @(negedge clk);
        bus.wr_en_in = !w; bus.wr_abort = !a; bus.rd_en_in = !r;
        wrdy = (mb[m_wb] == 0) || (mb[m_wb] == 1);
        rrdy = (mb[m_rb] >= 2);
        ab   = a && m_wfill;
        wacc = w && wrdy && !ab;
        racc = r && rrdy;
        #1;
        chk("wr_rdy",      int'(bus.wr_rdy),      int'(wrdy));
        chk("rd_rdy",      int'(bus.rd_rdy),      int'(rrdy));
        chk("mem_wr_en",   int'(bus.mem_wr_en),   int'(!wacc));
        chk("mem_rd_en",   int'(bus.mem_rd_en),   int'(!racc));
        chk("mem_wr_addr", int'(bus.mem_wr_addr), m_wb * FRAME + m_ww);
        chk("mem_rd_addr", int'(bus.mem_rd_addr), m_rb * FRAME + m_rw);
        e.fd  = int'(wacc && (m_ww == FRAME - 1));
        e.fr  = int'(racc && (m_rw == FRAME - 1));
        e.vld = int'(racc);
        if (ab) begin
            mb[m_wb] = 0; m_ww = 0; m_wfill = 1'b0;
        end else if (wacc) begin
            if (m_ww == FRAME - 1) begin
                mb[m_wb] = 2; m_ww = 0; m_wb = (m_wb + 1) % NB; m_wfill = 1'b0;
            end else begin
                mb[m_wb] = 1; m_ww++; m_wfill = 1'b1;
            end
        end
        if (racc) begin
            if (m_rw == FRAME - 1) begin
                mb[m_rb] = 0; m_rw = 0; m_rb = (m_rb + 1) % NB;
            end else begin
                mb[m_rb] = 3; m_rw++;
            end
        end
        cnt = 0;
        for (int i = 0; i < NB; i++) if (mb[i] >= 2) cnt++;
        e.full = cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("frame_done",  int'(bus.frame_done),  e.fd);
            chk("frame_read",  int'(bus.frame_read),  e.fr);
            chk("rd_data_vld", int'(bus.rd_data_vld), e.vld);
            chk("full_cnt",    int'(bus.full_cnt),    e.full);
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #2;
        chk_reset_vals("rst");
        @(negedge clk);
        reset = 1'b1;

        // single frame
        for (int i = 0; i < FRAME; i++) step(1, 0, 0);
        step(0, 0, 0);
        chk("sf.full1", int'(bus.full_cnt), 1);
        for (int i = 0; i < FRAME; i++) step(0, 0, 1);
        step(0, 0, 0);
        chk("sf.full0", int'(bus.full_cnt), 0);

        // buffers exhausted, then release to writer
        do_reset();
        for (int i = 0; i < 2 * FRAME; i++) step(1, 0, 0);
        chk("ex.wr_rdy", int'(bus.wr_rdy), 0);
        step(1, 0, 0);
        chk("ex.w17", int'(bus.mem_wr_en), 1);
        chk("ex.full", int'(bus.full_cnt), 2);
        for (int i = 0; i < FRAME - 1; i++) step(0, 0, 1);
        chk("rel.pre", int'(bus.wr_rdy), 0);
        step(0, 0, 1);
        chk("rel.wr_rdy", int'(bus.wr_rdy), 1);
        chk("rel.addr", int'(bus.mem_wr_addr), 0);
        step(1, 0, 0);

        // abort
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(1, 1, 0);
        chk("ab.addr", int'(bus.mem_wr_addr), 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0);

        // concurrent frame_done and frame_read
        do_reset();
        for (int i = 0; i < FRAME; i++) step(1, 0, 0);
        for (int i = 0; i < FRAME - 1; i++) step(1, 0, 1);
        step(1, 0, 1);
        chk("cc.done", int'(bus.frame_done), 1);
        chk("cc.read", int'(bus.frame_read), 1);
        chk("cc.full", int'(bus.full_cnt), 1);

        // random traffic
        do_reset();
        for (int i = 0; i < 120; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0);

        // asynchronous reset mid-frame
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        @(negedge clk);
        bus.wr_en_in = 1'b0; bus.rd_en_in = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("arst");
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        model_reset();
        step(1, 0, 0);
        chk("arst.next", int'(bus.mem_wr_addr), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/frame_buf_ctrl.md
# frame_buf_ctrl

Frame-level sequencer for a multi-buffer frame store built on `data_mem`. It divides one memory into `NUM_BUFS` frame buffers of `1 << ADDR_WIDTH` words each. It hands the writer the next free buffer and the reader the oldest full buffer, and it generates the memory enables and addresses for both. It sits between the pixel source/sink handshakes and a single `data_mem` instance, replacing per-port ad-hoc address FSMs.

## Interface

**Parameters**

- `ADDR_WIDTH`, 3: word address width within one frame; frame length is `1 << ADDR_WIDTH`.
- `NUM_BUFS`, 2: number of frame buffers; must be a power of 2 and at least 2.
- `BUF_W`, `$clog2(NUM_BUFS)`: buffer index width (derived).

**Ports**

- `clk` in 1: single clock; `data_mem` runs on the same clock.
- `reset` in 1: asynchronous, active-low (`ASSERT` = 0).
- `wr_en_in` in 1: writer offers a word this cycle; active-low.
- `wr_abort` in 1: discard the frame currently being filled; active-low.
- `rd_en_in` in 1: reader requests a word this cycle; active-low.
- `wr_rdy` out 1: a buffer is available for writing; active-high.
- `rd_rdy` out 1: a full or draining buffer is available; active-high.
- `mem_wr_en` out 1: `data_mem` write enable; active-low.
- `mem_rd_en` out 1: `data_mem` read enable; active-low.
- `mem_wr_addr` out `BUF_W+ADDR_WIDTH`: `{wr_buf, wr_word}`.
- `mem_rd_addr` out `BUF_W+ADDR_WIDTH`: `{rd_buf, rd_word}`.
- `rd_data_vld` out 1: `data_mem.rd_data` is valid this cycle; active-high.
- `frame_done` out 1: one-cycle pulse, a frame was completely written.
- `frame_read` out 1: one-cycle pulse, a frame was completely read.
- `full_cnt` out `BUF_W+1`: number of buffers in FULL or DRAINING.

## Operation

- Per-buffer state is one of FREE, FILLING, FULL, DRAINING. All buffers are FREE at reset.
- Buffers are allocated round-robin. `wr_buf` and `rd_buf` are pointers modulo `NUM_BUFS`, so frames are read in write order.
- **Writer FSM `W_WAIT -> W_FILL`**
  - In `W_WAIT`: `wr_rdy` = 1 iff buffer[`wr_buf`] is FREE. On an accepted write, buffer[`wr_buf`] becomes FILLING and the FSM enters `W_FILL`.
  - Write accept = `wr_en_in`==0 && `wr_rdy`. On accept, `mem_wr_en`=0 combinationally, `mem_wr_addr` = `{wr_buf, wr_word}`, and `wr_word` increments.
  - Accept with `wr_word` == all-ones (last word): buffer becomes FULL, `wr_buf`+1, `wr_word`=0, `frame_done` pulses, FSM returns to `W_WAIT`.
  - `wr_abort`==0 while in `W_FILL`: buffer returns to FREE, `wr_word`=0, `wr_buf` unchanged, FSM goes to `W_WAIT`. No write occurs that cycle, even if `wr_en_in`==0. In `W_WAIT`, `wr_abort` is ignored.
- **Reader FSM `R_WAIT -> R_READ`**, mirror of the writer.
  - `rd_rdy` = 1 iff buffer[`rd_buf`] is FULL or DRAINING.
  - Read accept = `rd_en_in`==0 && `rd_rdy`. On accept, `mem_rd_en`=0 combinationally, `mem_rd_addr` = `{rd_buf, rd_word}`, `rd_word` increments, and the buffer becomes DRAINING.
  - Last-word accept: buffer becomes FREE, `rd_buf`+1, `rd_word`=0, `frame_read` pulses.
- **Idle values**: when not accepting, `mem_wr_en` = `mem_rd_en` = 1, and the addresses hold their current pointer values.
- **Counter widths**: `wr_word` and `rd_word` wrap naturally at `ADDR_WIDTH` bits.
- **`full_cnt`**: increments on `frame_done`, decrements on `frame_read`. Both in the same cycle leaves it unchanged. It never exceeds `NUM_BUFS`.

## Timing

- **Reset values**: all enables 1; `wr_rdy`=1, `rd_rdy`=0; addresses 0; `rd_data_vld`, `frame_done`, `frame_read` = 0; `full_cnt`=0; both FSMs in WAIT.
- **Write**: zero-cycle accept; the word is written on the accepting edge.
- **Read**: `rd_data_vld` is asserted exactly 1 cycle after each read accept, matching the 1-cycle `data_mem` read latency.
- **Status pulses**: `frame_done` and `frame_read` are registered and assert the cycle after the last-word accept.
- **Buffer state and status**: buffer state updates on the edge. `wr_rdy` and `rd_rdy` are decoded from registered state, so a buffer freed by a read is writable from the next cycle, never the same cycle.
- **All buffers FULL**: `wr_rdy`=0; the writer stalls with no data loss.
- **All buffers FREE**: `rd_rdy`=0.
- **Write and read to the same buffer**: impossible by construction (FILLING excludes read, DRAINING excludes write).
- **Asynchronous reset mid-frame**: all state is cleared immediately, partial frames are discarded, and enables deassert without waiting for a clock.

## Structure

- **Shared package `frame_buf_pkg`**:
  - Buffer-state encoding: FREE=2'd0, FILLING=2'd1, FULL=2'd2, DRAINING=2'd3.
  - FSM encodings: W_WAIT/W_FILL, R_WAIT/R_READ.
  - `ASSERT`/`DEASSERT` constants.
- **Sub-module `frame_port_seq`**: one instance per side. It holds the port FSM, word counter, buffer pointer and last-word detect. Parameters select which buffer states it claims and releases.
- The buffer-state array and `full_cnt` stay in the top module.

## Test plan

All scenarios use `ADDR_WIDTH`=3 and `NUM_BUFS`=2 (8 words/frame).

- **Single frame**:
  - Stimulus: 8 consecutive writes of 0x000001..0x000008, then 8 reads.
  - Required: `mem_wr_addr` 0..7; `frame_done` at cycle 9; `full_cnt`=1; `mem_rd_addr` 0..7 with `rd_data_vld` lagging one cycle; `frame_read` pulse; `full_cnt`=0.
- **Buffers exhausted**:
  - Stimulus: 17 writes with no reads.
  - Required: buffers 0 and 1 FULL; `wr_rdy`=0 after write 16; write 17 not accepted (`mem_wr_en` stays 1); `full_cnt`=2.
- **Release to writer**:
  - Stimulus: from the exhausted state, read 8 words.
  - Required: `wr_rdy` rises the cycle after the 8th read; the next write goes to `mem_wr_addr` 0x0 (buffer 0).
- **Abort**:
  - Stimulus: write 3 words, then assert `wr_abort`.
  - Required: no write that cycle; the next write goes to `mem_wr_addr` 0x0 (same buffer, word 0); `frame_done` never pulses.
- **Concurrent pulses**:
  - Stimulus: complete a write and a read of different buffers in the same cycle.
  - Required: `frame_done` and `frame_read` both pulse; `full_cnt` unchanged.
- **Reset mid-frame**:
  - Stimulus: drive `reset`=0 asynchronously mid-frame.
  - Required: all outputs at reset values before the next edge; after release, the first write goes to address 0.
